// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-ROM bus, the redirect/halt controls and the IF/ID
// bundle handshake of the fetch stage.
//   master : fetch stage side (drives ROM address, bundle, fetch count and state)
//   slave  : environment side (ROM data, redirect, halt, decode ready)
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              jbr_taken;
  logic [31:0]       jbr_target;
  logic              halt;
  logic              fd_valid;
  logic              fd_ready;
  logic [31:0]       fd_pc;
  logic [31:0]       fd_inst;
  logic [31:0]       fetch_cnt;
  logic [1:0]        state_o;

  modport master (
    output inst_addr, fd_valid, fd_pc, fd_inst, fetch_cnt, state_o,
    input  inst_rdata, jbr_taken, jbr_target, halt, fd_ready
  );

  modport slave (
    input  inst_addr, fd_valid, fd_pc, fd_inst, fetch_cnt, state_o,
    output inst_rdata, jbr_taken, jbr_target, halt, fd_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of an asynchronous instruction ROM.
// Holds the PC, drives the ROM word address, captures the returned word into the IF/ID
// bundle register and offers it to decode over a valid/ready handshake. Accepts redirects
// from downstream and a sticky halt request.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : fetch_stage_if.master (ROM address/data, jbr_taken/jbr_target, halt,
//            fd_valid/fd_ready/fd_pc/fd_inst bundle, fetch_cnt, state_o)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic           clk,
  input  logic           resetn,
  fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_inst_q, fd_inst_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        load;

  // The bundle slot is free when empty or being consumed this cycle.
  assign load = !fd_valid_q || bus.fd_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fd_valid_d  = fd_valid_q;
    fd_pc_d     = fd_pc_q;
    fd_inst_d   = fd_inst_q;
    fetch_cnt_d = fetch_cnt_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (bus.halt) begin
          state_d = StHalt;
          if (bus.fd_ready) fd_valid_d = 1'b0;
        end else if (bus.jbr_taken) begin
          // Squashes both the held bundle and the word fetched this cycle.
          pc_d       = bus.jbr_target & ~32'h3;
          fd_valid_d = 1'b0;
        end else if (load) begin
          fd_valid_d  = 1'b1;
          fd_pc_d     = pc_q;
          fd_inst_d   = bus.inst_rdata;
          pc_d        = pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      StHalt: begin
        if (bus.fd_ready) fd_valid_d = 1'b0;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      fd_valid_q  <= 1'b0;
      fd_pc_q     <= 32'h0;
      fd_inst_q   <= 32'h0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fd_valid_q  <= fd_valid_d;
      fd_pc_q     <= fd_pc_d;
      fd_inst_q   <= fd_inst_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Out-of-range PCs simply truncate onto the ROM index.
  assign bus.inst_addr = pc_q[ADDR_W+1:2];
  assign bus.fd_valid  = fd_valid_q;
  assign bus.fd_pc     = fd_pc_q;
  assign bus.fd_inst   = fd_inst_q;
  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table for the documented scenarios, then randomized
// traffic checked cycle by cycle against a queue-based reference model.
module tb_fetch_stage;
  localparam int unsigned AW = 6;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk;
  logic resetn;
  logic [31:0] rom [64];

  fetch_stage_if #(.ADDR_W(AW)) bus ();

  fetch_stage #(.RESET_PC(RPC), .ADDR_W(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.inst_rdata = rom[bus.inst_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } bnd_t;

  bnd_t        mq[$];      // bundle presented to decode (0 or 1 entries)
  int          m_mode;     // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc, m_last_pc, m_last_inst, m_cnt;

  task automatic model_reset();
    mq.delete();
    m_mode      = 0;
    m_pc        = RPC;
    m_last_pc   = 0;
    m_last_inst = 0;
    m_cnt       = 0;
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      m_mode = 1;
    end else begin
      // Decode consumes first, then redirect squashes, then an empty slot refills.
      if (bus.fd_ready && mq.size() != 0) void'(mq.pop_front());
      if (m_mode == 1) begin
        if (bus.halt) begin
          m_mode = 2;
        end else if (bus.jbr_taken) begin
          mq.delete();
          m_pc = {bus.jbr_target[31:2], 2'b00};
        end else if (mq.size() == 0) begin
          m_last_pc   = m_pc;
          m_last_inst = rom[m_pc[AW+1:2]];
          mq.push_back('{pc: m_last_pc, inst: m_last_inst});
          m_pc  = m_pc + 4;
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(bus.fd_valid), 32'(mq.size() != 0));
    chk("fd_pc", bus.fd_pc, m_last_pc);
    chk("fd_inst", bus.fd_inst, m_last_inst);
    chk("fetch_cnt", bus.fetch_cnt, m_cnt);
    chk("inst_addr", 32'(bus.inst_addr), 32'(m_pc[AW+1:2]));
    chk("state", 32'(bus.state_o), 32'(m_mode));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"}, 32'(bus.fd_valid), 0);
    chk({tag, " fd_pc"}, bus.fd_pc, 0);
    chk({tag, " fd_inst"}, bus.fd_inst, 0);
    chk({tag, " fetch_cnt"}, bus.fetch_cnt, 0);
    chk({tag, " inst_addr"}, 32'(bus.inst_addr), 32'(RPC[AW+1:2]));
    chk({tag, " state"}, 32'(bus.state_o), 0);
  endtask

  // Called 1 time unit after a rising edge: reset drops mid-cycle.
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    bus.halt = 0; bus.jbr_taken = 0; bus.jbr_target = 0; bus.fd_ready = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        halt;
    logic        jbr;
    logic [31:0] tgt;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_cnt;
    logic [5:0]  exp_addr;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t tv[$];
  vec_t wv[$];

  function automatic vec_t mk(logic h, logic j, logic [31:0] t, logic r, logic v,
                              logic [31:0] p, logic [31:0] i, logic [31:0] c,
                              logic [5:0] a, logic [1:0] s);
    vec_t x;
    x.halt = h; x.jbr = j; x.tgt = t; x.rdy = r; x.exp_v = v;
    x.exp_pc = p; x.exp_inst = i; x.exp_cnt = c; x.exp_addr = a; x.exp_st = s;
    return x;
  endfunction

  task automatic apply_vec(input vec_t x, input int idx);
    string tag;
    bus.halt = x.halt; bus.jbr_taken = x.jbr; bus.jbr_target = x.tgt; bus.fd_ready = x.rdy;
    step();
    tag = $sformatf("vec%0d", idx);
    chk({tag, " valid"}, 32'(bus.fd_valid), 32'(x.exp_v));
    chk({tag, " fd_pc"}, bus.fd_pc, x.exp_pc);
    chk({tag, " fd_inst"}, bus.fd_inst, x.exp_inst);
    chk({tag, " fetch_cnt"}, bus.fetch_cnt, x.exp_cnt);
    chk({tag, " inst_addr"}, 32'(bus.inst_addr), 32'(x.exp_addr));
    chk({tag, " state"}, 32'(bus.state_o), 32'(x.exp_st));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC000_0000 | (i << 8) | i;
    rom[0]  = 32'h2401_0001;
    rom[1]  = 32'h0001_1100;
    rom[2]  = 32'h0041_1821;
    rom[3]  = 32'h0002_2082;
    rom[13] = 32'h8C2A_0013;

    resetn = 1'b0;
    bus.halt = 0; bus.jbr_taken = 0; bus.jbr_target = 0; bus.fd_ready = 0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Boot, straight-line fetch, backpressure.
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h00, rom[0], 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h04, rom[1], 2, 2, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h08, rom[2], 3, 3, 1));
    for (int k = 0; k < 3; k++) tv.push_back(mk(0, 0, 0, 0, 1, 32'h08, rom[2], 3, 3, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h0C, rom[3], 4, 4, 1));
    for (int k = 4; k < 12; k++)
      tv.push_back(mk(0, 0, 0, 1, 1, 32'(4 * k), rom[k], 32'(k + 1), 6'(k + 1), 1));
    // Redirects while decode stalls.
    tv.push_back(mk(0, 1, 32'h34, 0, 0, 32'h2C, rom[11], 12, 13, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h34, rom[13], 13, 14, 1));
    tv.push_back(mk(0, 1, 32'h4E, 0, 0, 32'h34, rom[13], 13, 19, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h4C, rom[19], 14, 20, 1));
    // Halt wins over a simultaneous redirect; bundle drains once, redirects ignored.
    tv.push_back(mk(1, 1, 32'h58, 0, 1, 32'h4C, rom[19], 14, 20, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h4C, rom[19], 14, 20, 2));
    tv.push_back(mk(0, 0, 0, 1, 0, 32'h4C, rom[19], 14, 20, 2));
    tv.push_back(mk(0, 1, 0, 1, 0, 32'h4C, rom[19], 14, 20, 2));
    tv.push_back(mk(1, 1, 32'h10, 0, 0, 32'h4C, rom[19], 14, 20, 2));
    foreach (tv[i]) apply_vec(tv[i], i);

    // Reset from HALT, BOOT repeats, then PC wrap.
    async_reset();
    wv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    wv.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 63, 1));
    wv.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, rom[63], 1, 0, 1));
    wv.push_back(mk(0, 0, 0, 1, 1, 32'h0000_0000, rom[0], 2, 1, 1));
    foreach (wv[i]) apply_vec(wv[i], 100 + i);

    // Randomized traffic against the model, with a mid-run reset after each round.
    for (int r = 0; r < 6; r++) begin
      async_reset();
      for (int c = 0; c < 200; c++) begin
        bus.halt       = ($urandom_range(0, 149) == 0);
        bus.jbr_taken  = ($urandom_range(0, 7) == 0);
        bus.jbr_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                     : $urandom;
        bus.fd_ready   = ($urandom_range(0, 9) < 7);
        step();
        check_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the asynchronous instruction ROM.
- Holds the PC and drives the ROM word address. Captures the returned instruction into an IF/ID bundle register.
- Hands the bundle to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream and a halt request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 6, ROM word-address width; inst_addr = pc[ADDR_W+1:2].

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- resetn, in, 1, asynchronous active-low reset.
- inst_addr, out, ADDR_W, word address to the instruction ROM; combinational from pc.
- inst_rdata, in, 32, ROM instruction, valid in the same cycle as inst_addr.
- jbr_taken, in, 1, redirect request from decode/execute.
- jbr_target, in, 32, redirect target byte address.
- halt, in, 1, stop fetching (sticky until reset).
- fd_valid, out, 1, IF/ID bundle valid.
- fd_ready, in, 1, decode accepts the bundle this cycle.
- fd_pc, out, 32, PC of the bundled instruction.
- fd_inst, out, 32, bundled instruction.
- fetch_cnt, out, 32, number of instructions loaded into the bundle since reset.
- state_o, out, 2, current state: BOOT=0, RUN=1, HALT=2.

Behaviour:
- Reset (resetn=0, takes effect immediately, not on a clock edge):
  - pc=RESET_PC, state=BOOT.
  - fd_valid=0, fd_pc=0, fd_inst=0, fetch_cnt=0.
  - Reset mid-operation discards any bundle and redirect.
- inst_addr = pc[ADDR_W+1:2] at all times, including in BOOT and HALT. A PC beyond ROM depth truncates; the ROM returns 0 (nop) for unimplemented words.
- BOOT: exactly one cycle after resetn rises; no fetch, no bundle load. Next state is RUN unconditionally (halt is sampled only in RUN).
- RUN, define load = !fd_valid || fd_ready. Per cycle, in priority order:
  1. halt=1 → state<=HALT; no load. If fd_ready, fd_valid<=0; otherwise the held bundle stays. pc is frozen.
  2. jbr_taken=1 → pc<={jbr_target[31:2],2'b00}; fd_valid<=0 (squashes both the held bundle and this cycle's fetch), regardless of fd_ready. fetch_cnt unchanged.
  3. load=1 → fd_valid<=1, fd_pc<=pc, fd_inst<=inst_rdata, pc<=pc+4, fetch_cnt<=fetch_cnt+1.
  4. Otherwise (fd_valid && !fd_ready) → stall: pc, fd_pc, fd_inst, fetch_cnt hold.
- Latency: an instruction at PC p appears on fd_* one cycle after pc==p in RUN with load=1. Throughput is one instruction per cycle with fd_ready=1.
- Redirect penalty: one bubble cycle (fd_valid=0), then the target bundle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. fetch_cnt wraps at 2^32.
- HALT:
  - No loads; jbr_taken ignored; pc and fetch_cnt frozen.
  - fd_valid clears on the first cycle with fd_ready=1 and stays 0 thereafter.
  - Exit only via reset.
- fd_pc/fd_inst keep their last values when fd_valid=0. Decode must qualify them with fd_valid.

Test Plan:
1. Reset release, fd_ready=1, ROM loaded with program:
   - Cycle after BOOT: inst_addr=0.
   - Next cycles: fd bundles (0x00, 0x24010001), (0x04, 0x00011100), (0x08, 0x00411821).
   - fetch_cnt counts 1, 2, 3.
2. Backpressure:
   - While fd_pc=0x08, fd_valid=1: hold fd_ready=0 for 3 cycles → fd_pc, fd_inst, pc=0x0C and fetch_cnt=3 all stable.
   - Raise fd_ready → next bundle fd_pc=0x0C, inst 0x00022082.
3. Redirect:
   - jbr_taken=1, jbr_target=0x34 while fd_pc=0x2C, fd_ready=0 → next cycle fd_valid=0, pc=0x34.
   - Following cycle: fd_pc=0x34, fd_inst=0x8C2A0013.
   - Repeat with jbr_target=0x4E → pc=0x4C.
4. Halt with simultaneous redirect:
   - halt=1, jbr_taken=1 (target 0x58), fd_ready=0 → state=HALT, pc unchanged, bundle held.
   - Raise fd_ready → fd_valid=0 permanently; fetch_cnt frozen; later jbr_taken has no effect.
5. PC wrap: force a redirect to 0xFFFF_FFFC with fd_ready=1 → bundle fd_pc=0xFFFF_FFFC, then pc=0x0000_0000, inst_addr=0.
6. Async reset mid-run: drop resetn between clock edges → fd_valid, fd_pc, fd_inst and fetch_cnt go to 0 and pc to RESET_PC before the next edge, then the BOOT cycle is repeated on release.
